// File: rtl/alu_mult_seq.sv
// Shift-add multiply sequencer that borrows the shared 16-bit ALU for its adds; low-word product.
// Optional macro MULT_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module alu_mult_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_zr,
  output logic             prod_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             last_iter;

`ifdef MULT_EARLY_EXIT_EN
  // Once the remaining multiplier bits are all zero, further adds cannot change P.
  assign last_iter = ((q_q >> 1) == '0) || (count_q == CNT_W'(WIDTH - 1));
`else
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    alu_zx    = 1'b1;
    alu_nx    = 1'b0;
    alu_zy    = 1'b1;
    alu_ny    = 1'b0;
    alu_f     = 1'b0;
    alu_no    = 1'b0;

    case (state_q)
      RUN: begin
        // ALU computes P + M; accepted only when the current multiplier bit is set.
        alu_zx  = 1'b0;
        alu_zy  = 1'b0;
        alu_f   = 1'b1;
        if (q_q[0]) p_d = alu_out;
        m_d     = m_q << 1;
        q_d     = q_q >> 1;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          product_d = p_d;
          state_d   = FIN;
        end
      end
      default: begin
        if (start) begin
          p_d     = '0;
          m_d     = a;
          q_d     = b;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign alu_x   = p_q;
  assign alu_y   = m_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == FIN);
  assign product = product_q;
  assign prod_zr = (product_q == '0);
  assign prod_ng = product_q[WIDTH-1];

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
Multi-cycle shift-add multiply sequencer that borrows the shared 16-bit combinational ALU to compute 16x16 -> 16-bit (low word) products.
- Drives the ALU operands and the six control bits (zx,nx,zy,ny,f,no) each cycle and captures the ALU result.
- Sits beside the CPU datapath as a multiply coprocessor.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/product width; must match the ALU width.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE or FIN
- a  input  WIDTH  multiplicand; captured when start is accepted
- b  input  WIDTH  multiplier; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in FIN
- product  output  WIDTH  result register; held until the next accepted start
- prod_zr  output  1  product == 0
- prod_ng  output  1  product[WIDTH-1]
- alu_x  output  WIDTH  ALU x operand
- alu_y  output  WIDTH  ALU y operand
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits
- alu_out  input  WIDTH  ALU result, combinational from alu_x/alu_y/control in the same cycle

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, prod_zr=1, prod_ng=0, internal P/M/Q/count=0.
- Reset mid-RUN aborts the operation; the next cycle is IDLE with the reset values above.
- State IDLE:
  - ALU control = zx=1,nx=0,zy=1,ny=0,f=0,no=0 (ALU out=0).
  - alu_x=P, alu_y=M.
  - On start=1: load P<=0, M<=a, Q<=b, count<=0; go to RUN.
- State RUN (busy=1):
  - ALU control = 0,0,0,0,1,0 (x+y); alu_x=P, alu_y=M.
  - Each cycle: if Q[0]=1 then P<=alu_out, else P holds.
  - Each cycle: M<=M<<1 (MSB dropped), Q<=Q>>1 (zero fill), count<=count+1.
  - When count==WIDTH-1: product<=next P; go to FIN.
  - Arithmetic is modulo 2^WIDTH; overflow is silently discarded.
  - Low word is correct for both signed and unsigned operands.
- State FIN: done=1, busy=0, same ALU control as IDLE.
  - start=1 is accepted exactly as in IDLE (loads operands, goes to RUN); otherwise go to IDLE.
- Latency: start accepted at edge N; RUN occupies cycles N+1..N+WIDTH; product updates at edge N+WIDTH; done high in the cycle following that edge.
- Throughput: back-to-back operations with start held in FIN give one result per WIDTH+1 cycles.
- start while in RUN is ignored; a/b changes during RUN have no effect.
- prod_zr and prod_ng are combinational from the product register only, never from alu_out.
- No ALU ownership arbitration; the integrating top level muxes the ALU using busy.

Optional Feature:
Macro MULT_EARLY_EXIT_EN.
- Defined: in RUN, if (Q>>1)==0 in the current cycle, the cycle is the last one. product<=next P and go to FIN regardless of count. RUN always lasts at least one cycle; b=0 finishes after 1 RUN cycle. Latency = max(1, index of highest set bit of b + 1) RUN cycles.
- Undefined: RUN always lasts exactly WIDTH cycles. No early-exit logic is synthesized.

Test Plan:
- a=3, b=5, start one cycle -> busy for 16 cycles; done pulse; product=0x000F, prod_zr=0, prod_ng=0. With MULT_EARLY_EXIT_EN: busy 3 cycles, same result.
- a=0xFFFF, b=0xFFFF (-1*-1) -> product=0x0001; a=0x7FFF, b=2 -> product=0xFFFE, prod_ng=1.
- a=0x1234, b=0 -> product=0x0000, prod_zr=1. With feature: busy exactly 1 cycle.
- start pulses with a=7, b=9 mid-RUN of op 3*5 -> ignored; result 0x000F; a single done pulse.
- start held high through FIN with new a=2, b=6 -> first done shows 0x000F; RUN restarts immediately; second done shows 0x000C.
- reset=1 at RUN cycle 8 -> next cycle IDLE, busy=0, done=0, product=0, prod_zr=1; ALU control reads 1,0,1,0,0,0.
